fifo_stream: RTL and testbench
==============================

Name: fifo_stream

Overview:
- Parametrised successor to the team's basic synchronous FIFO: single clock, valid/ready write and read ports, first-word-fall-through read data.
- Adds:
  - simultaneous push/pop at any fill level, including full
  - arbitrary (non-power-of-two) depth
  - fill-level output
  - programmable almost-full/almost-empty flags
  - synchronous flush
  - high-watermark register
- Used as the generic elastic buffer between streaming stages.

Parameters:
- DataWidth, 8, bits per entry (>=1).
- Depth, 16, number of entries (>=2, any integer; pointers wrap explicitly, no power-of-two requirement).
- AlmostFullThr, Depth-2, almost_full_o asserts when level >= this value (1..Depth).
- AlmostEmptyThr, 2, almost_empty_o asserts when level <= this value (0..Depth-1).
- LW (localparam), $clog2(Depth+1), width of level outputs.

Ports:
- clk_i, in, 1, clock; all state updates on rising edge.
- reset_ni, in, 1, asynchronous active-low reset.
- flush_i, in, 1, synchronous flush; empties the FIFO on the next edge.
- wvalid_i, in, 1, write request.
- wready_o, out, 1, FIFO can accept a write.
- data_i, in, DataWidth, write data.
- rvalid_o, out, 1, head entry is valid.
- rready_i, in, 1, consumer accepts the head entry.
- data_o, out, DataWidth, head entry (first-word-fall-through).
- level_o, out, LW, current entry count (0..Depth).
- max_level_o, out, LW, highest level reached since reset or flush.
- is_full_o, out, 1, level == Depth.
- is_empty_o, out, 1, level == 0.
- almost_full_o, out, 1, level >= AlmostFullThr.
- almost_empty_o, out, 1, level <= AlmostEmptyThr.

Behaviour:
- Reset (reset_ni low, asynchronous assert, synchronous deassert handled upstream):
  - write pointer, read pointer, level and max_level clear to 0.
  - Outputs while in reset: is_empty_o=1, rvalid_o=0, wready_o=1, almost_empty_o=1, is_full_o=0, almost_full_o=0, level_o=0, max_level_o=0.
  - Storage array is not reset.
- Handshakes:
  - push = wvalid_i & wready_o; pop = rvalid_o & rready_i.
  - wready_o = !is_full_o and rvalid_o = !is_empty_o, each from registered level only. No combinational path from rready_i to wready_o or from wvalid_i to rvalid_o.
- Data path:
  - data_o = storage[rd_ptr] combinationally. It is only meaningful while rvalid_o=1 and stays stable until popped.
  - Write-to-read latency is 1 cycle: data pushed at edge N is visible on data_o after edge N when the FIFO was empty. There is no same-cycle bypass.
- Pointers:
  - Increment on push (write pointer) and on pop (read pointer).
  - Each wraps from Depth-1 to 0 explicitly.
- Level update per edge:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance
  - neither: hold
- Full with simultaneous pop: wready_o=0, so no push occurs; level drops to Depth-1.
- Empty: rvalid_o=0, so no pop occurs; data_o is don't-care.
- max_level_o: updated each edge to max(max_level_o, next level); monotonic until reset or flush.
- flush_i:
  - Has priority over push and pop in the same cycle. Pointers, level and max_level go to 0 and any concurrent push is discarded.
  - Flags reflect empty from the next cycle.
- Flags are pure decodes of the registered level, so all flags change only on clock edges.
- No overflow or underflow is possible through the handshake. Assertions must check that level_o never exceeds Depth and that pushes and pops only occur with ready/valid high.

Test Plan:
- Reset, then push 0x11..0x1F with rready_i=0 into Depth=16 → level_o steps 1..15, almost_full_o rises at level 14, then push 0x20: is_full_o=1, wready_o=0, max_level_o=16; further wvalid_i is ignored.
- Drain the full FIFO with rready_i=1 → data_o sequence 0x11..0x20 in order; is_empty_o after 16 pops; almost_empty_o asserts at level 2.
- Depth=5, 12 continuous push+pop cycles after pre-filling 2 entries → level_o stays 2, pointers wrap 4→0, output order is preserved, max_level_o=2.
- Full FIFO, wvalid_i=1 and rready_i=1 in the same cycle → one pop only, level 16→15; on the next cycle push and pop both happen, level stays 15.
- Level 7 with flush_i=1 and wvalid_i=1 in the same cycle → next cycle level_o=0, max_level_o=0, is_empty_o=1; the pushed word is never output.
- Assert reset_ni mid-burst between clock edges → outputs go to reset values immediately, without waiting for a clock edge; after release the first push of 0xAB appears on data_o one cycle later.

Source files
------------

// File: rtl/fifo_stream.sv
// Single-clock elastic buffer with valid/ready ports and first-word-fall-through read data.
// Supports any depth, fill level and watermark outputs, programmable almost flags, and synchronous flush.
module fifo_stream #(
   parameter  int DataWidth       = 8,
   parameter  int Depth           = 16,
   parameter  int AlmostFullThr   = Depth - 2,
   parameter  int AlmostEmptyThr  = 2,
   localparam int LW              = $clog2(Depth + 1)
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 flush_i,
   input  logic                 wvalid_i,
   output logic                 wready_o,
   input  logic [DataWidth-1:0] data_i,
   output logic                 rvalid_o,
   input  logic                 rready_i,
   output logic [DataWidth-1:0] data_o,
   output logic [LW-1:0]        level_o,
   output logic [LW-1:0]        max_level_o,
   output logic                 is_full_o,
   output logic                 is_empty_o,
   output logic                 almost_full_o,
   output logic                 almost_empty_o
);

   localparam int PW = $clog2(Depth);

   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]        level_q, level_d;
   logic [LW-1:0]        max_level_q, max_level_d;
   logic [DataWidth-1:0] mem_q [Depth];
   logic                 push, pop;

   // All flags decode the registered level only, so ready/valid never depend on the opposite port.
   assign is_full_o      = (level_q == LW'(Depth));
   assign is_empty_o     = (level_q == '0);
   assign almost_full_o  = (level_q >= LW'(AlmostFullThr));
   assign almost_empty_o = (level_q <= LW'(AlmostEmptyThr));
   assign wready_o       = !is_full_o;
   assign rvalid_o       = !is_empty_o;
   assign level_o        = level_q;
   assign max_level_o    = max_level_q;
   assign data_o         = mem_q[rd_ptr_q];

   assign push = wvalid_i & wready_o;
   assign pop  = rvalid_o & rready_i;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      max_level_d = max_level_q;
      if (flush_i) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         max_level_d = '0;
      end else begin
         // Explicit wrap keeps non-power-of-two depths correct.
         if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(Depth - 1)) ? '0 : wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(Depth - 1)) ? '0 : rd_ptr_q + PW'(1);
         end
         case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
         max_level_d = (level_d > max_level_q) ? level_d : max_level_q;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         max_level_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         max_level_q <= max_level_d;
      end
   end

   // Storage carries no reset; a push racing a flush is dropped.
   always_ff @(posedge clk_i) begin
      if (push && !flush_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   a_level_bound: assert property (@(posedge clk_i) disable iff (!reset_ni)
      level_q <= LW'(Depth));
   a_push_ready: assert property (@(posedge clk_i) disable iff (!reset_ni)
      push |-> (wvalid_i && !is_full_o));
   a_pop_valid: assert property (@(posedge clk_i) disable iff (!reset_ni)
      pop |-> (rready_i && !is_empty_o));

endmodule

// File: tb/tb_fifo_stream.sv
// Bench for fifo_stream: a Depth=16 and a Depth=5 instance driven side by side,
// each compared every cycle against a queue-based reference model.
module tb_fifo_stream;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic rst_b;

   logic       fl_a, wv_a, rr_a, wr_a, rv_a, full_a, empty_a, af_a, ae_a;
   logic [7:0] di_a, do_a;
   logic [4:0] lvl_a, max_a;

   logic       fl_b, wv_b, rr_b, wr_b, rv_b, full_b, empty_b, af_b, ae_b;
   logic [7:0] di_b, do_b;
   logic [2:0] lvl_b, max_b;

   fifo_stream #(.DataWidth(8), .Depth(16)) dut_a (
      .clk_i(clk_sys), .reset_ni(rst_b), .flush_i(fl_a),
      .wvalid_i(wv_a), .wready_o(wr_a), .data_i(di_a),
      .rvalid_o(rv_a), .rready_i(rr_a), .data_o(do_a),
      .level_o(lvl_a), .max_level_o(max_a), .is_full_o(full_a), .is_empty_o(empty_a),
      .almost_full_o(af_a), .almost_empty_o(ae_a)
   );

   fifo_stream #(.DataWidth(8), .Depth(5), .AlmostFullThr(3), .AlmostEmptyThr(1)) dut_b (
      .clk_i(clk_sys), .reset_ni(rst_b), .flush_i(fl_b),
      .wvalid_i(wv_b), .wready_o(wr_b), .data_i(di_b),
      .rvalid_o(rv_b), .rready_i(rr_b), .data_o(do_b),
      .level_o(lvl_b), .max_level_o(max_b), .is_full_o(full_b), .is_empty_o(empty_b),
      .almost_full_o(af_b), .almost_empty_o(ae_b)
   );

   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   int mmax_a = 0;
   int mmax_b = 0;
   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outs(input string p, input int d, input int aft, input int aet,
                             input int lvl, input int head, input int mx,
                             input logic [31:0] o_lvl, input logic [31:0] o_max,
                             input logic o_full, input logic o_empty, input logic o_af,
                             input logic o_ae, input logic o_wr, input logic o_rv,
                             input logic [7:0] o_data);
      chk({p, ".level"},        o_lvl,   lvl);
      chk({p, ".max_level"},    o_max,   mx);
      chk({p, ".is_full"},      32'(o_full),  32'(lvl == d));
      chk({p, ".is_empty"},     32'(o_empty), 32'(lvl == 0));
      chk({p, ".almost_full"},  32'(o_af),    32'(lvl >= aft));
      chk({p, ".almost_empty"}, 32'(o_ae),    32'(lvl <= aet));
      chk({p, ".wready"},       32'(o_wr),    32'(lvl < d));
      chk({p, ".rvalid"},       32'(o_rv),    32'(lvl > 0));
      if (lvl > 0) chk({p, ".data"}, 32'(o_data), head);
   endtask

   task automatic check_all();
      int ha, hb;
      ha = (q_a.size() > 0) ? int'(q_a[0]) : 0;
      hb = (q_b.size() > 0) ? int'(q_b[0]) : 0;
      check_outs("a", 16, 14, 2, q_a.size(), ha, mmax_a, 32'(lvl_a), 32'(max_a),
                 full_a, empty_a, af_a, ae_a, wr_a, rv_a, do_a);
      check_outs("b", 5, 3, 1, q_b.size(), hb, mmax_b, 32'(lvl_b), 32'(max_b),
                 full_b, empty_b, af_b, ae_b, wr_b, rv_b, do_b);
   endtask

   task automatic step(input logic fa, input logic wa, input logic [7:0] da, input logic ra,
                       input logic fb, input logic wb, input logic [7:0] db, input logic rb);
      bit push_a, pop_a, push_b, pop_b;
      fl_a = fa; wv_a = wa; di_a = da; rr_a = ra;
      fl_b = fb; wv_b = wb; di_b = db; rr_b = rb;
      push_a = wa && (q_a.size() < 16);
      pop_a  = ra && (q_a.size() > 0);
      push_b = wb && (q_b.size() < 5);
      pop_b  = rb && (q_b.size() > 0);
      @(posedge clk_sys);
      #1;
      if (fa) begin
         q_a.delete(); mmax_a = 0;
      end else begin
         if (pop_a)  void'(q_a.pop_front());
         if (push_a) q_a.push_back(da);
         if (q_a.size() > mmax_a) mmax_a = q_a.size();
      end
      if (fb) begin
         q_b.delete(); mmax_b = 0;
      end else begin
         if (pop_b)  void'(q_b.pop_front());
         if (push_b) q_b.push_back(db);
         if (q_b.size() > mmax_b) mmax_b = q_b.size();
      end
      check_all();
   endtask

   task automatic step_a(input logic f, input logic w, input logic [7:0] d, input logic r);
      step(f, w, d, r, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic step_b(input logic f, input logic w, input logic [7:0] d, input logic r);
      step(1'b0, 1'b0, 8'h00, 1'b0, f, w, d, r);
   endtask

   initial begin
      fl_a = 0; wv_a = 0; di_a = 0; rr_a = 0;
      fl_b = 0; wv_b = 0; di_b = 0; rr_b = 0;
      rst_b = 1'b0;
      #12;
      check_all();
      @(negedge clk_sys);
      rst_b = 1'b1;

      // fill to full, then extra writes must be ignored
      for (int i = 0; i < 16; i++) step_a(1'b0, 1'b1, 8'h11 + 8'(i), 1'b0);
      chk("a.full_after_16", 32'(full_a), 32'd1);
      for (int i = 0; i < 2; i++) step_a(1'b0, 1'b1, 8'h55, 1'b0);

      // drain in order
      for (int i = 0; i < 16; i++) begin
         chk("a.drain_order", 32'(do_a), 32'(8'h11 + 8'(i)));
         step_a(1'b0, 1'b0, 8'h00, 1'b1);
      end
      chk("a.empty_after_drain", 32'(empty_a), 32'd1);

      // full with simultaneous write and read
      for (int i = 0; i < 16; i++) step_a(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0);
      step_a(1'b0, 1'b1, 8'h66, 1'b1);
      chk("a.full_pop_only", 32'(lvl_a), 32'd15);
      step_a(1'b0, 1'b1, 8'h77, 1'b1);
      chk("a.push_pop_hold", 32'(lvl_a), 32'd15);
      for (int i = 0; i < 16; i++) step_a(1'b0, 1'b0, 8'h00, 1'b1);

      // flush at level 7 racing a push
      for (int i = 0; i < 7; i++) step_a(1'b0, 1'b1, 8'h40 + 8'(i), 1'b0);
      step_a(1'b1, 1'b1, 8'hEE, 1'b0);
      chk("a.flush_level", 32'(lvl_a), 32'd0);
      chk("a.flush_max", 32'(max_a), 32'd0);
      step_a(1'b0, 1'b0, 8'h00, 1'b1);
      step_a(1'b0, 1'b1, 8'h12, 1'b0);
      chk("a.post_flush_head", 32'(do_a), 32'h12);
      step_a(1'b0, 1'b0, 8'h00, 1'b1);

      // small non-power-of-two depth, streaming at constant level
      step_b(1'b0, 1'b1, 8'hA0, 1'b0);
      step_b(1'b0, 1'b1, 8'hA1, 1'b0);
      for (int i = 0; i < 12; i++) step_b(1'b0, 1'b1, 8'hB0 + 8'(i), 1'b1);
      chk("b.stream_level", 32'(lvl_b), 32'd2);
      chk("b.stream_max", 32'(max_b), 32'd2);
      chk("b.stream_head", 32'(do_b), 32'hBA);

      // random traffic on both instances
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 47) == 0, $urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1,
              $urandom_range(0, 47) == 0, $urandom_range(0, 9) < 5, 8'($urandom), $urandom_range(0, 9) < 5);
      end

      // asynchronous reset in the middle of a burst
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b1, 8'hD0 + 8'(i), 1'b0);
      #2;
      rst_b = 1'b0;
      #1;
      q_a.delete(); q_b.delete(); mmax_a = 0; mmax_b = 0;
      check_all();
      fl_a = 0; wv_a = 0; rr_a = 0; fl_b = 0; wv_b = 0; rr_b = 0;
      @(negedge clk_sys);
      rst_b = 1'b1;
      step_a(1'b0, 1'b1, 8'hAB, 1'b0);
      chk("a.post_reset_head", 32'(do_a), 32'hAB);
      step_a(1'b0, 1'b0, 8'h00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
